// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback with anti-starvation
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_src,
  output logic              alu_starved
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic starve;
  // Loads win by default; a saturated wait counter hands the port to the ALU
  always_comb begin
    starve    = wait_cnt == MAXW;
    alu_ready = !rst && alu_valid && (!mem_valid || starve);
    mem_ready = !rst && mem_valid && !(alu_valid && starve);
    wait_nxt  = alu_ready ? '0 : alu_valid ? (starve ? MAXW : wait_cnt + 1'b1) : '0;
  end
  // Register the accepted write; x0 targets complete but never assert the write enable
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write   <= 1'b0;
      rd          <= '0;
      write_data  <= '0;
      grant_src   <= 1'b0;
      wait_cnt    <= '0;
      alu_starved <= 1'b0;
    end else begin
      reg_write   <= alu_ready ? alu_rd != '0 : mem_ready && mem_rd != '0;
      rd          <= alu_ready ? alu_rd : mem_ready ? mem_rd : rd;
      write_data  <= alu_ready ? alu_data : mem_ready ? mem_data : write_data;
      grant_src   <= alu_ready ? 1'b0 : mem_ready ? 1'b1 : grant_src;
      wait_cnt    <= wait_nxt;
      alu_starved <= wait_nxt == MAXW;
    end
  end
endmodule
